// File: rtl/toggle_event_decoder.sv
// toggle_event_decoder
// Converts a toggle-encoded event line (one event per level change on t_in)
// into a counted event queue with a valid/ready pop interface. Each delivered
// event is acknowledged back to the sender as one toggle on ack_q.
//
// Optional feature macro: TOGGLE_DEC_SYNC_EN
//   defined   : t_in passes a two-flop synchronizer, event latency 3 clocks
//   undefined : t_in sampled by one register (must be clk-synchronous), latency 2
//
// Ports
//   clk           in   sole clock, rising edge
//   rst_n         in   synchronous active-low reset
//   t_in          in   toggle-encoded event line
//   ev_ready      in   consumer takes one event this cycle
//   clr_ovf       in   clears the sticky overflow flag
//   ev_valid      out  at least one event pending
//   pending       out  number of undelivered events (CNT_W bits)
//   ack_q         out  toggle-encoded acknowledge, one toggle per pop
//   ack_q_inverse out  complement of ack_q
//   overflow      out  sticky, an event was dropped at full count
module toggle_event_decoder #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             t_in,
    input  logic             ev_ready,
    input  logic             clr_ovf,
    output logic             ev_valid,
    output logic [CNT_W-1:0] pending,
    output logic             ack_q,
    output logic             ack_q_inverse,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             s_q;
    logic             t_prev_q;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             valid_q;
    logic             ack_d,   ack_r_q, ack_inv_q;
    logic             ovf_d,   ovf_q;
    logic             evt_c;
    logic             pop_c;

    // Input sampling stage; s_q is always the final sampling register
`ifdef TOGGLE_DEC_SYNC_EN
    logic s1_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s_q  <= 1'b0;
        end else begin
            s1_q <= t_in;
            s_q  <= s1_q;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q <= 1'b0;
        end else begin
            s_q <= t_in;
        end
    end
`endif

    // Any level change between consecutive samples is one event
    assign evt_c = s_q ^ t_prev_q;
    // Pop only when something is held, so ready at zero never wraps or acks
    assign pop_c = (cnt_q != '0) && ev_ready;

    // Counter / acknowledge / overflow next-state
    always_comb begin
        cnt_d = cnt_q;
        ack_d = ack_r_q;
        ovf_d = ovf_q && !clr_ovf;

        if (pop_c) begin
            ack_d = ~ack_r_q;
        end

        if (evt_c && !pop_c) begin
            if (cnt_q == CNT_MAX) begin
                // Drop wins over clear so a lost event is never hidden
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop_c && !evt_c) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t_prev_q  <= 1'b0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            ack_r_q   <= 1'b0;
            ack_inv_q <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            t_prev_q  <= s_q;
            cnt_q     <= cnt_d;
            valid_q   <= (cnt_d != '0);
            ack_r_q   <= ack_d;
            ack_inv_q <= ~ack_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ev_valid      = valid_q;
    assign pending       = cnt_q;
    assign ack_q         = ack_r_q;
    assign ack_q_inverse = ack_inv_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Testbench for toggle_event_decoder: a behavioural model predicts the
// outputs for every clock; predictions are queued when inputs are driven and
// popped for comparison one step after the rising edge.
module tb_toggle_event_decoder;

    localparam int unsigned CNT_W = 4;
    localparam int          MAXV  = (1 << CNT_W) - 1;
`ifdef TOGGLE_DEC_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             t_in;
    logic             ev_ready;
    logic             clr_ovf;
    logic             ev_valid;
    logic [CNT_W-1:0] pending;
    logic             ack_q;
    logic             ack_q_inverse;
    logic             overflow;

    toggle_event_decoder #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .t_in          (t_in),
        .ev_ready      (ev_ready),
        .clr_ovf       (clr_ovf),
        .ev_valid      (ev_valid),
        .pending       (pending),
        .ack_q         (ack_q),
        .ack_q_inverse (ack_q_inverse),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pend;
        bit valid;
        bit ack;
        bit ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Model state: h[0] is the t_in value seen at the last edge, h[1] the one before, ...
    int m_pend;
    bit m_ack;
    bit m_ovf;
    bit h[3];
    bit tv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one rising edge with the given inputs
    task automatic model_edge(input bit t, input bit rdy, input bit clr, input bit rst);
        bit ev;
        bit pop;
        if (rst) begin
            m_pend = 0;
            m_ack  = 1'b0;
            m_ovf  = 1'b0;
            h      = '{1'b0, 1'b0, 1'b0};
        end else begin
            ev  = (LAT == 3) ? (h[1] ^ h[2]) : (h[0] ^ h[1]);
            pop = (m_pend != 0) && rdy;
            m_ovf = m_ovf && !clr;
            if (pop) m_ack = !m_ack;
            if (ev && !pop) begin
                if (m_pend == MAXV) m_ovf = 1'b1;
                else m_pend++;
            end else if (pop && !ev) begin
                m_pend--;
            end
            h[2] = h[1];
            h[1] = h[0];
            h[0] = t;
        end
    endtask

    // Drive one clock of inputs, queue the prediction, then compare after the edge
    task automatic step(input bit t, input bit rdy, input bit clr, input bit rst);
        exp_t e;
        t_in     = t;
        ev_ready = rdy;
        clr_ovf  = clr;
        rst_n    = !rst;
        model_edge(t, rdy, clr, rst);
        e.pend  = m_pend;
        e.valid = (m_pend != 0);
        e.ack   = m_ack;
        e.ovf   = m_ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("pending",   32'(pending),       32'(e.pend));
        check("ev_valid",  32'(ev_valid),      32'(e.valid));
        check("ack_q",     32'(ack_q),         32'(e.ack));
        check("ack_q_inv", 32'(ack_q_inverse), 32'(!e.ack));
        check("overflow",  32'(overflow),      32'(e.ovf));
    endtask

    task automatic do_reset(input int cycles);
        tv = 1'b0;
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle(input int cycles, input bit rdy);
        for (int i = 0; i < cycles; i++) step(tv, rdy, 1'b0, 1'b0);
    endtask

    task automatic toggles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) begin
            tv = !tv;
            step(tv, rdy, 1'b0, 1'b0);
        end
    endtask

    // Toggle now and pop exactly in the cycle the event reaches the counter
    task automatic toggle_with_pop();
        toggles(1, 1'b0);
        idle(LAT - 2, 1'b0);
        idle(1, 1'b1);
    endtask

    initial begin
        t_in = 1'b0; ev_ready = 1'b0; clr_ovf = 1'b0; rst_n = 1'b0;
        m_pend = 0; m_ack = 1'b0; m_ovf = 1'b0; h = '{1'b0, 1'b0, 1'b0}; tv = 1'b0;

        // Reset state
        do_reset(2);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_ack_inv", 32'(ack_q_inverse), 32'd1);

        // Single event latency
        toggles(1, 1'b0);
        idle(LAT - 2, 1'b0);
        check("lat_not_yet", 32'(pending), 32'd0);
        idle(1, 1'b0);
        check("lat_pending", 32'(pending), 32'd1);
        check("lat_valid",   32'(ev_valid), 32'd1);
        check("lat_ack",     32'(ack_q), 32'd0);

        // Five back-to-back toggles, then drain
        do_reset(1);
        toggles(5, 1'b0);
        idle(LAT, 1'b0);
        check("five_pending", 32'(pending), 32'd5);
        check("five_ovf",     32'(overflow), 32'd0);
        idle(5, 1'b1);
        check("drain_pending", 32'(pending), 32'd0);
        check("drain_ack",     32'(ack_q), 32'd1);
        check("drain_ack_inv", 32'(ack_q_inverse), 32'd0);

        // Saturation and overflow clear
        do_reset(1);
        toggles(16, 1'b0);
        idle(LAT, 1'b0);
        check("sat_pending", 32'(pending), 32'(MAXV));
        check("sat_ovf",     32'(overflow), 32'd1);
        step(tv, 1'b0, 1'b1, 1'b0);
        check("clr_ovf",      32'(overflow), 32'd0);
        check("clr_pending",  32'(pending), 32'(MAXV));

        // Event and pop together at full count
        toggle_with_pop();
        check("full_pop_pending", 32'(pending), 32'(MAXV));
        check("full_pop_ovf",     32'(overflow), 32'd0);
        check("full_pop_ack",     32'(ack_q), 32'd1);
        idle(MAXV, 1'b1);
        idle(3, 1'b1);
        check("empty_rdy_pending", 32'(pending), 32'd0);
        check("empty_rdy_ack",     32'(ack_q), 32'd0);

        // Event and pop together at pending = 3
        do_reset(1);
        toggles(3, 1'b0);
        idle(LAT, 1'b0);
        toggle_with_pop();
        check("mid_pop_pending", 32'(pending), 32'd3);
        check("mid_pop_ack",     32'(ack_q), 32'd1);

        // Mid-operation reset
        do_reset(1);
        toggles(4, 1'b0);
        idle(LAT, 1'b1);
        idle(0, 1'b0);
        do_reset(1);
        toggles(4, 1'b0);
        idle(LAT, 1'b0);
        check("pre_rst_pending", 32'(pending), 32'd4);
        do_reset(1);
        check("post_rst_pending", 32'(pending), 32'd0);
        check("post_rst_valid",   32'(ev_valid), 32'd0);
        check("post_rst_ack",     32'(ack_q), 32'd0);

        // t_in high across reset release counts as one event
        tv = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(LAT, 1'b0);
        check("release_high", 32'(pending), 32'd1);

        // Random traffic against the model
        do_reset(1);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 60) tv = !tv;
            step(tv, 1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 99) < 5),
                 1'($urandom_range(0, 299) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
